// File: rtl/shift_cmd_seq_pkg.sv
// Shared constants for the shift command sequencer: shifter op codes, FSM states, widths.
package shift_cmd_seq_pkg;

  localparam int unsigned SEQ_DW       = 8;
  localparam int unsigned SEQ_AMT_W    = 3;
  localparam int unsigned SEQ_MAX_STEP = 3;
  localparam int unsigned SHAMT_W      = 2;
  localparam int unsigned OP_W         = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Only the three shift ops are valid requests; anything else passes data through.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/shift_cmd_seq_if.sv
// Request, shifter-command and response signals of the shift sequencer.
// Optional SHIFT_CMD_SEQ_ERR_EN adds rsp_err.
interface shift_cmd_seq_if
  import shift_cmd_seq_pkg::*;
#(
  parameter int unsigned DW    = SEQ_DW,
  parameter int unsigned AMT_W = SEQ_AMT_W
) ();

  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [AMT_W-1:0]    req_amt;
  logic [DW-1:0]       req_data;
  logic [OP_W-1:0]     sh_op;
  logic [SHAMT_W-1:0]  sh_shamt;
  logic [DW-1:0]       sh_d_in;
  logic [DW-1:0]       sh_d_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DW-1:0]       rsp_data;
`ifdef SHIFT_CMD_SEQ_ERR_EN
  logic                rsp_err;
`endif

  // Sequencer side: initiates shifter commands and produces responses.
  modport master (
    input  req_valid, req_op, req_amt, req_data, sh_d_out, rsp_ready,
    output req_ready, sh_op, sh_shamt, sh_d_in, rsp_valid, rsp_data
`ifdef SHIFT_CMD_SEQ_ERR_EN
    , output rsp_err
`endif
  );

  modport slave (
    output req_valid, req_op, req_amt, req_data, sh_d_out, rsp_ready,
    input  req_ready, sh_op, sh_shamt, sh_d_in, rsp_valid, rsp_data
`ifdef SHIFT_CMD_SEQ_ERR_EN
    , input rsp_err
`endif
  );

endinterface

// File: rtl/shift_step_sel.sv
// Picks the next shift step: min(remaining, MAX_STEP), and flags the final step.
module shift_step_sel #(
  parameter int unsigned AMT_W    = 3,
  parameter int unsigned MAX_STEP = 3,
  parameter int unsigned STEP_W   = 2
) (
  input  logic [AMT_W-1:0]  remaining,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  always_comb begin
    last = (remaining <= MAX_STEP_A);
    step = last ? STEP_W'(remaining) : STEP_W'(MAX_STEP);
  end

endmodule

// File: rtl/shift_cmd_seq.sv
// Sequencer that turns one shift request into LOAD plus 1..MAX_STEP-bit shifter steps.
// Optional SHIFT_CMD_SEQ_ERR_EN adds rsp_err for illegal request ops.
module shift_cmd_seq
  import shift_cmd_seq_pkg::*;
#(
  parameter int unsigned DW       = SEQ_DW,
  parameter int unsigned AMT_W    = SEQ_AMT_W,
  parameter int unsigned MAX_STEP = SEQ_MAX_STEP
) (
  input logic              clk,
  input logic              reset,
  shift_cmd_seq_if.master  bus
);

  state_e              state, state_d;
  logic [OP_W-1:0]     op_q;
  logic [AMT_W-1:0]    amt_q;
  logic [DW-1:0]       data_q;
  logic                illegal_q;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic                accept;

  logic                req_ready_q, req_ready_d;
  logic [OP_W-1:0]     sh_op_q, sh_op_d;
  logic [SHAMT_W-1:0]  sh_shamt_q, sh_shamt_d;
  logic [DW-1:0]       sh_d_in_q;
  logic                rsp_valid_q, rsp_valid_d;

  logic [SHAMT_W-1:0]  step;
  logic                last;

  shift_step_sel #(
    .AMT_W    (AMT_W),
    .MAX_STEP (MAX_STEP),
    .STEP_W   (SHAMT_W)
  ) u_step_sel (
    .remaining (rem_q),
    .step      (step),
    .last      (last)
  );

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d     = state;
    rem_d       = rem_q;
    accept      = 1'b0;
    sh_op_d     = OP_NOP;
    sh_shamt_d  = '0;
    rsp_valid_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sh_op_d = OP_LOAD;
        rem_d   = amt_q;
        state_d = ((amt_q == '0) || illegal_q) ? RESP : SHIFT;
      end
      SHIFT: begin
        sh_op_d    = op_q;
        sh_shamt_d = step;
        rem_d      = rem_q - AMT_W'(step);
        if (last) state_d = RESP;
      end
      RESP: begin
        // rsp_valid lags entry by a cycle so the last shifter step has landed.
        if (rsp_valid_q && bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= '0;
      amt_q       <= '0;
      data_q      <= '0;
      illegal_q   <= 1'b0;
      rem_q       <= '0;
      req_ready_q <= 1'b1;
      sh_op_q     <= OP_NOP;
      sh_shamt_q  <= '0;
      sh_d_in_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      rem_q       <= rem_d;
      req_ready_q <= req_ready_d;
      sh_op_q     <= sh_op_d;
      sh_shamt_q  <= sh_shamt_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        op_q      <= bus.req_op;
        amt_q     <= bus.req_amt;
        data_q    <= bus.req_data;
        illegal_q <= !op_legal(bus.req_op);
      end
      if (state == LOAD) sh_d_in_q <= data_q;
    end
  end

`ifdef SHIFT_CMD_SEQ_ERR_EN
  logic rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= rsp_valid_d && illegal_q;
  end

  assign bus.rsp_err = rsp_err_q;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.sh_op     = sh_op_q;
  assign bus.sh_shamt  = sh_shamt_q;
  assign bus.sh_d_in   = sh_d_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  // The shifter holds its value during RESP, so the result is taken straight from it.
  assign bus.rsp_data  = rsp_valid_q ? bus.sh_d_out : '0;

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq paired with a behavioural Shifter8 register.
module tb_shift_cmd_seq;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  shift_cmd_seq_if bus ();

  shift_cmd_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Shifter8 model answering the command port.
  logic [7:0] sh_reg;
  always @(posedge clk) begin
    if (reset) sh_reg <= 8'h00;
    else begin
      case (bus.sh_op)
        3'b001:  sh_reg <= bus.sh_d_in;
        3'b010:  sh_reg <= sh_reg << bus.sh_shamt;
        3'b011:  sh_reg <= sh_reg >> bus.sh_shamt;
        3'b100:  sh_reg <= 8'($signed(sh_reg) >>> bus.sh_shamt);
        default: sh_reg <= sh_reg;
      endcase
    end
  end
  assign bus.sh_d_out = sh_reg;

  // Command monitor: counts LOADs, shift steps and total shift issued.
  int n_load, n_steps, amt_sum;
  always @(negedge clk) begin
    if (bus.sh_op == 3'b001) n_load++;
    if (bus.sh_op == 3'b010 || bus.sh_op == 3'b011 || bus.sh_op == 3'b100) begin
      n_steps++;
      amt_sum += int'(bus.sh_shamt);
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp_data;
    int         exp_lat;
    int         exp_steps;
    int         exp_sum;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request; returns after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_amt   = amt;
    bus.req_data  = data;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_load  = 0;
    n_steps = 0;
    amt_sum = 0;
    check("accept", 32'(bus.req_ready), 32'd0);
  endtask

  // Edges after the accept edge until rsp_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) lat = i;
    end
  endtask

  task automatic finish_handshake(input string name);
    @(posedge clk);
    #1;
    check({name, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "_req_ready_rise"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{3'b010, 3'd1, 8'hB5, 8'h6A, 3, 1, 1, 1'b0};
    vecs[1]  = '{3'b011, 3'd5, 8'hB5, 8'h05, 4, 2, 5, 1'b0};
    vecs[2]  = '{3'b100, 3'd7, 8'hB5, 8'hFF, 5, 3, 7, 1'b0};
    vecs[3]  = '{3'b111, 3'd4, 8'h3C, 8'h3C, 2, 0, 0, 1'b1};
    vecs[4]  = '{3'b010, 3'd3, 8'h81, 8'h08, 3, 1, 3, 1'b0};
    vecs[5]  = '{3'b011, 3'd6, 8'hF0, 8'h03, 4, 2, 6, 1'b0};
    vecs[6]  = '{3'b100, 3'd4, 8'h80, 8'hF8, 4, 2, 4, 1'b0};
    vecs[7]  = '{3'b010, 3'd7, 8'hFF, 8'h80, 5, 3, 7, 1'b0};
    vecs[8]  = '{3'b001, 3'd2, 8'h55, 8'h55, 2, 0, 0, 1'b1};
    vecs[9]  = '{3'b100, 3'd3, 8'h7F, 8'h0F, 3, 1, 3, 1'b0};
    vecs[10] = '{3'b000, 3'd0, 8'h99, 8'h99, 2, 0, 0, 1'b1};
    vecs[11] = '{3'b011, 3'd0, 8'h5A, 8'h5A, 2, 0, 0, 1'b0};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_amt   = 3'd0;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_sh_op",     32'(bus.sh_op),     32'd0);
    check("reset_sh_shamt",  32'(bus.sh_shamt),  32'd0);
    check("reset_sh_d_in",   32'(bus.sh_d_in),   32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef SHIFT_CMD_SEQ_ERR_EN
    check("reset_rsp_err",   32'(bus.rsp_err),   32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      issue(vecs[v].op, vecs[v].amt, vecs[v].data);
      wait_valid(lat);
      check($sformatf("v%0d_latency", v), 32'(lat),            32'(vecs[v].exp_lat));
      check($sformatf("v%0d_data", v),    32'(bus.rsp_data),   32'(vecs[v].exp_data));
      check($sformatf("v%0d_loads", v),   32'(n_load),         32'd1);
      check($sformatf("v%0d_steps", v),   32'(n_steps),        32'(vecs[v].exp_steps));
      check($sformatf("v%0d_amt_sum", v), 32'(amt_sum),        32'(vecs[v].exp_sum));
`ifdef SHIFT_CMD_SEQ_ERR_EN
      check($sformatf("v%0d_err", v),     32'(bus.rsp_err),    32'(vecs[v].exp_err));
`endif
      finish_handshake($sformatf("v%0d", v));
    end

    // Response held while the consumer stalls.
    bus.rsp_ready = 1'b0;
    issue(3'b010, 3'd0, 8'hA5);
    wait_valid(lat);
    check("hold_latency", 32'(lat), 32'd2);
    check("hold_data0", 32'(bus.rsp_data), 32'hA5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("hold%0d_rsp_data", k),  32'(bus.rsp_data),  32'hA5);
      check($sformatf("hold%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    finish_handshake("hold");

    // Reset in the second SHIFT cycle aborts without a response.
    issue(3'b100, 3'd7, 8'hB5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_sh_op",     32'(bus.sh_op),     32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    issue(3'b010, 3'd2, 8'h01);
    wait_valid(lat);
    check("post_abort_latency", 32'(lat), 32'd3);
    check("post_abort_data", 32'(bus.rsp_data), 32'h04);
    finish_handshake("post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
